// File: rtl/dmem_if.sv
// dmem_if: request/response bus between the MEM stage and the data-memory responder
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory answering one load/store at a fixed latency
module dmem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input logic   clk,
    input logic   reset,
    dmem_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic                  we_q;
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            be_q;
    logic                  req_ready;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic                  busy;
    logic [31:0]           mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  err;
    logic                  commit;

    assign idx    = addr_q[DEPTH_LOG2+1:2];
    assign err    = (addr_q[1:0] != 2'b00) || ((addr_q >> (DEPTH_LOG2 + 2)) != 32'd0);
    assign commit = (state == WAIT) && (cnt == 4'd0);

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_rdata;
    assign bus.rsp_err   = rsp_err;
    assign bus.busy      = busy;

    // Request FSM: accept in IDLE, count down in WAIT, strobe the registered response in RESP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            be_q      <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    if (bus.req_valid) begin
                        we_q      <= bus.req_we;
                        addr_q    <= bus.req_addr;
                        wdata_q   <= bus.req_wdata;
                        be_q      <= bus.req_be;
                        cnt       <= 4'(LATENCY - 1);
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= err;
                        rsp_rdata <= (err || we_q) ? 32'd0 : mem[idx];
                        busy      <= 1'b0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Byte-lane store commit on the edge entering RESP; storage is never reset
    always_ff @(posedge clk) begin
        if (commit && we_q && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end
endmodule
